// File: rtl/wca_tx_feeder_pkg.sv
// Shared types and constants for the TX sample feeder path.
package wca_tx_feeder_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned WORD_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_e;

  typedef enum logic {
    PH_I = 1'b0,
    PH_Q = 1'b1
  } pack_phase_e;

  // Converter word order: Q in the upper half, I in the lower half.
  function automatic logic [SAMPLE_W-1:0] pack_iq(input logic [WORD_W-1:0] q,
                                                  input logic [WORD_W-1:0] i);
    return {q, i};
  endfunction

endpackage

// File: rtl/wca_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, show-ahead read port.
// Registered level/full/empty; synchronous flush has priority over traffic.
module wca_sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  empty
);

  localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  assign w_push  = wr_en && !r_full;
  assign w_pop   = rd_en && !r_empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;
  assign full    = r_full;
  assign empty   = r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_empty <= (w_level_nxt == '0);
    end
  end

endmodule

// File: rtl/wca_tx_sample_feeder.sv
// TX baseband sample feeder: packs I/Q host words into 32-bit samples,
// buffers them, primes before streaming and zero-fills on underflow.
module wca_tx_sample_feeder
  import wca_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned PRIME_LEVEL = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    aclr,
  input  logic [WORD_W-1:0]       din,
  input  logic                    din_we,
  output logic                    din_full,
  input  logic                    strobe_bb,
  output logic [SAMPLE_W-1:0]     iq_bb_out,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    running,
  output logic                    underflow,
  output logic                    overflow,
  input  logic                    status_clr
);

  localparam logic [DEPTH_LOG2:0] PRIME_LVL = PRIME_LEVEL[DEPTH_LOG2:0];

  feeder_state_e          r_state;
  feeder_state_e          w_state_nxt;
  pack_phase_e            r_phase;
  logic [WORD_W-1:0]      r_i_word;
  logic [SAMPLE_W-1:0]    r_iq;
  logic                   r_underflow;
  logic                   r_overflow;

  logic                   w_go_idle;
  logic                   w_active;
  logic                   w_wr_q;
  logic                   w_fifo_wr;
  logic                   w_ovf_set;
  logic                   w_fifo_rd;
  logic                   w_uf_set;
  logic [SAMPLE_W-1:0]    w_fifo_data;
  logic [DEPTH_LOG2:0]    w_level;
  logic                   w_full;
  logic                   w_empty;

  assign w_go_idle = !enable || aclr;
  assign w_active  = (r_state != ST_IDLE) && !w_go_idle;
  assign w_wr_q    = w_active && din_we && (r_phase == PH_Q);
  // Full is the registered flag, so a same-cycle pop does not rescue the pair.
  assign w_fifo_wr = w_wr_q && !w_full;
  assign w_ovf_set = w_wr_q && w_full;

  wca_sync_fifo #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .flush   (w_go_idle),
    .wr_en   (w_fifo_wr),
    .wr_data (pack_iq(din, r_i_word)),
    .rd_en   (w_fifo_rd),
    .rd_data (w_fifo_data),
    .level   (w_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and underflow detection.
  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = 1'b0;
    w_uf_set    = 1'b0;
    if (w_go_idle) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_PRIME;
        ST_PRIME: begin
          if (w_level >= PRIME_LVL) begin
            w_state_nxt = ST_RUN;
            w_fifo_rd   = 1'b1;
          end
        end
        ST_RUN: begin
          if (strobe_bb) begin
            if (!w_empty) begin
              w_fifo_rd = 1'b1;
            end else begin
              w_uf_set    = 1'b1;
              w_state_nxt = ST_PRIME;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // I/Q pack phase and latched I word; a partial pair dies with IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase  <= PH_I;
      r_i_word <= '0;
    end else if (w_go_idle) begin
      r_phase  <= PH_I;
    end else if (w_active && din_we) begin
      if (r_phase == PH_I) begin
        r_i_word <= din;
        r_phase  <= PH_Q;
      end else begin
        r_phase  <= PH_I;
      end
    end
  end

  // Output sample register: loaded on pop, zeroed outside RUN and on underflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_iq <= '0;
    end else if (w_go_idle) begin
      r_iq <= '0;
    end else if (w_fifo_rd) begin
      r_iq <= w_fifo_data;
    end else if (w_uf_set || (r_state != ST_RUN)) begin
      r_iq <= '0;
    end
  end

  // Sticky status flags; a set event wins over status_clr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (aclr) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_uf_set)        r_underflow <= 1'b1;
      else if (status_clr) r_underflow <= 1'b0;
      if (w_ovf_set)       r_overflow  <= 1'b1;
      else if (status_clr) r_overflow  <= 1'b0;
    end
  end

  assign din_full  = w_full;
  assign iq_bb_out = r_iq;
  assign level     = w_level;
  assign running   = (r_state == ST_RUN);
  assign underflow = r_underflow;
  assign overflow  = r_overflow;

endmodule
